// File: rtl/sd_init_ctrl.sv
// microSD SPI-mode power-up sequencer: idle clocks, CMD0, CMD8, CMD55/ACMD41 loop, CMD58.
// Drives a byte-wide SPI engine over a start/done handshake and owns the card chip-select.
module sd_init_ctrl #(
   parameter int POWERUP_BYTES  = 10,
   parameter int NCR_MAX        = 8,
   parameter int ACMD41_RETRIES = 1000
) (
   input  logic       CLK50,
   input  logic       RST_N,
   input  logic       START,
   output logic       SPI_START,
   output logic [7:0] SPI_TX,
   input  logic       SPI_DONE,
   input  logic [7:0] SPI_RX,
   output logic       CS,
   output logic       READY,
   output logic       SDHC,
   output logic       ERR,
   output logic [2:0] ERR_CODE
);

   typedef enum logic [3:0] {
      S_IDLE, S_POWERUP, S_CMD, S_R1, S_TAIL, S_GAP, S_CHECK, S_DONE, S_ERROR
   } state_t;

   typedef enum logic [2:0] {C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58} cmd_t;

   localparam logic [7:0]  PWR_LAST  = 8'(POWERUP_BYTES - 1);
   localparam logic [7:0]  NCR_LAST  = 8'(NCR_MAX - 1);
   localparam logic [15:0] RETRY_LIM = 16'(ACMD41_RETRIES);

   state_t      state, state_nxt;
   cmd_t        cmd, cmd_nxt;
   logic        pending, pending_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [15:0] retry, retry_nxt, retry_inc;
   logic [7:0]  r1, r1_nxt;
   logic [31:0] tail, tail_nxt;
   logic        sdhc_nxt;
   logic [2:0]  err_code_nxt;
   logic        byte_ok;
   logic        unused_tail;

   function automatic logic [7:0] frame_byte(input cmd_t c, input logic [2:0] idx);
      logic [47:0] frame;
      case (c)
         C_CMD0:   frame = 48'h400000000095;
         C_CMD8:   frame = 48'h48000001AA87;
         C_CMD55:  frame = 48'h770000000065;
         C_ACMD41: frame = 48'h694000000077;
         C_CMD58:  frame = 48'h7A00000000FD;
         default:  frame = 48'hFFFFFFFFFFFF;
      endcase
      frame = frame << {idx, 3'b000};
      return frame[47:40];
   endfunction

   // A completion only counts when a byte is actually outstanding; stray pulses are dropped.
   assign byte_ok     = pending & SPI_DONE;
   assign retry_inc   = retry + 16'd1;
   assign READY       = (state == S_DONE);
   assign ERR         = (state == S_ERROR);
   assign unused_tail = ^{tail[31], tail[29:12]};

   always_ff @(posedge CLK50 or negedge RST_N) begin
      if (!RST_N) begin
         state    <= S_IDLE;
         cmd      <= C_CMD0;
         pending  <= 1'b0;
         cnt      <= '0;
         retry    <= '0;
         r1       <= '0;
         tail     <= '0;
         SDHC     <= 1'b0;
         ERR_CODE <= '0;
      end else begin
         state    <= state_nxt;
         cmd      <= cmd_nxt;
         pending  <= pending_nxt;
         cnt      <= cnt_nxt;
         retry    <= retry_nxt;
         r1       <= r1_nxt;
         tail     <= tail_nxt;
         SDHC     <= sdhc_nxt;
         ERR_CODE <= err_code_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cmd_nxt      = cmd;
      pending_nxt  = pending & ~SPI_DONE;
      cnt_nxt      = cnt;
      retry_nxt    = retry;
      r1_nxt       = r1;
      tail_nxt     = tail;
      sdhc_nxt     = SDHC;
      err_code_nxt = ERR_CODE;
      SPI_START    = 1'b0;
      SPI_TX       = 8'hFF;
      CS           = 1'b1;

      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (START) begin
               state_nxt    = S_POWERUP;
               cmd_nxt      = C_CMD0;
               pending_nxt  = 1'b0;
               cnt_nxt      = '0;
               retry_nxt    = '0;
               sdhc_nxt     = 1'b0;
               err_code_nxt = '0;
            end
         end
         S_POWERUP: begin
            SPI_START = ~pending;
            if (byte_ok) begin
               cnt_nxt = cnt + 8'd1;
               if (cnt == PWR_LAST) begin
                  state_nxt = S_CMD;
                  cnt_nxt   = '0;
               end
            end
         end
         S_CMD: begin
            CS        = 1'b0;
            SPI_TX    = frame_byte(cmd, cnt[2:0]);
            SPI_START = ~pending;
            if (byte_ok) begin
               cnt_nxt = cnt + 8'd1;
               if (cnt == 8'd5) begin
                  state_nxt = S_R1;
                  cnt_nxt   = '0;
               end
            end
         end
         S_R1: begin
            CS        = 1'b0;
            SPI_START = ~pending;
            if (byte_ok) begin
               cnt_nxt = cnt + 8'd1;
               if (!SPI_RX[7]) begin
                  r1_nxt    = SPI_RX;
                  cnt_nxt   = '0;
                  state_nxt = (cmd == C_CMD8 || cmd == C_CMD58) ? S_TAIL : S_GAP;
               end else if (cnt == NCR_LAST) begin
                  state_nxt    = S_ERROR;
                  err_code_nxt = 3'd5;
               end
            end
         end
         S_TAIL: begin
            CS        = 1'b0;
            SPI_START = ~pending;
            if (byte_ok) begin
               tail_nxt = {tail[23:0], SPI_RX};
               cnt_nxt  = cnt + 8'd1;
               if (cnt == 8'd3) begin
                  state_nxt = S_GAP;
                  cnt_nxt   = '0;
               end
            end
         end
         S_GAP: begin
            SPI_START = ~pending;
            if (byte_ok) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            cnt_nxt   = '0;
            state_nxt = S_CMD;
            case (cmd)
               C_CMD0: begin
                  if (r1 != 8'h01) begin
                     state_nxt    = S_ERROR;
                     err_code_nxt = 3'd1;
                  end else cmd_nxt = C_CMD8;
               end
               C_CMD8: begin
                  if (r1 != 8'h01 || tail[11:0] != 12'h1AA) begin
                     state_nxt    = S_ERROR;
                     err_code_nxt = 3'd2;
                  end else cmd_nxt = C_CMD55;
               end
               C_CMD55: begin
                  if (r1[7:1] != 7'd0) begin
                     state_nxt    = S_ERROR;
                     err_code_nxt = 3'd3;
                  end else cmd_nxt = C_ACMD41;
               end
               C_ACMD41: begin
                  if (r1 == 8'h00) begin
                     cmd_nxt = C_CMD58;
                  end else if (r1 == 8'h01 && retry_inc != RETRY_LIM) begin
                     retry_nxt = retry_inc;
                     cmd_nxt   = C_CMD55;
                  end else begin
                     retry_nxt    = retry_inc;
                     state_nxt    = S_ERROR;
                     err_code_nxt = 3'd3;
                  end
               end
               C_CMD58: begin
                  if (r1 != 8'h00) begin
                     state_nxt    = S_ERROR;
                     err_code_nxt = 3'd4;
                  end else begin
                     sdhc_nxt  = tail[30];
                     state_nxt = S_DONE;
                  end
               end
               default: state_nxt = S_IDLE;
            endcase
         end
         default: state_nxt = S_IDLE;
      endcase

      if (SPI_START) pending_nxt = 1'b1;
   end

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Directed bench for sd_init_ctrl: SPI byte engine plus a scripted SD card responder.
`timescale 1ns/1ps
module tb_sd_init_ctrl;

   logic       CLK50    = 1'b0;
   logic       RST_N    = 1'b1;
   logic       START    = 1'b0;
   logic       SPI_START;
   logic [7:0] SPI_TX;
   logic       SPI_DONE = 1'b0;
   logic [7:0] SPI_RX   = 8'hFF;
   logic       CS;
   logic       READY;
   logic       SDHC;
   logic       ERR;
   logic [2:0] ERR_CODE;

   sd_init_ctrl #(
      .POWERUP_BYTES  (10),
      .NCR_MAX        (8),
      .ACMD41_RETRIES (4)
   ) dut (
      .CLK50     (CLK50),
      .RST_N     (RST_N),
      .START     (START),
      .SPI_START (SPI_START),
      .SPI_TX    (SPI_TX),
      .SPI_DONE  (SPI_DONE),
      .SPI_RX    (SPI_RX),
      .CS        (CS),
      .READY     (READY),
      .SDHC      (SDHC),
      .ERR       (ERR),
      .ERR_CODE  (ERR_CODE)
   );

   always #10 CLK50 = ~CLK50;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // card configuration (written by the stimulus process only)
   bit          cfg_no_resp   = 1'b0;
   logic [31:0] cfg_cmd8_tail = 32'h000001AA;
   int          cfg_busy      = 3;
   logic [31:0] cfg_ocr       = 32'hC0FF8000;
   int          run_id        = 0;

   // engine/card state (written by the engine process only)
   logic [7:0] tx_log[$];
   logic       cs_log[$];
   logic [7:0] card_q[$];
   int         card_fidx = 0;
   logic [5:0] card_cmd  = '0;
   int         n_cmd55   = 0;
   int         n_acmd41  = 0;
   int         overlap   = 0;

   task automatic push_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) card_q.push_back(w[i*8 +: 8]);
   endtask

   task automatic card_respond();
      card_q.delete();
      if (cfg_no_resp) return;
      card_q.push_back(8'hFF);
      case (card_cmd)
         6'd0:  card_q.push_back(8'h01);
         6'd8:  begin card_q.push_back(8'h01); push_word(cfg_cmd8_tail); end
         6'd55: begin n_cmd55++; card_q.push_back(8'h01); end
         6'd41: begin
            n_acmd41++;
            card_q.push_back((n_acmd41 > cfg_busy) ? 8'h00 : 8'h01);
         end
         6'd58: begin card_q.push_back(8'h00); push_word(cfg_ocr); end
         default: card_q.push_back(8'h04);
      endcase
   endtask

   task automatic card_xfer(input logic [7:0] tx, input logic cs, output logic [7:0] rx);
      rx = 8'hFF;
      if (cs) begin
         card_q.delete();
         card_fidx = 0;
         return;
      end
      if (card_fidx == 0 && card_q.size() > 0) rx = card_q.pop_front();
      if (card_fidx == 0) begin
         if (tx[7:6] == 2'b01) begin
            card_cmd  = tx[5:0];
            card_fidx = 1;
         end
      end else begin
         card_fidx++;
         if (card_fidx == 6) begin
            card_fidx = 0;
            card_respond();
         end
      end
   endtask

   initial begin : engine
      int         seen_run;
      logic [7:0] tx, rx;
      logic       cs;
      seen_run = 0;
      forever begin
         @(negedge CLK50);
         SPI_DONE = 1'b0;
         if (seen_run != run_id) begin
            seen_run  = run_id;
            card_q.delete();
            card_fidx = 0;
            n_cmd55   = 0;
            n_acmd41  = 0;
         end
         if (SPI_START === 1'b1) begin
            tx = SPI_TX;
            cs = CS;
            tx_log.push_back(tx);
            cs_log.push_back(cs);
            card_xfer(tx, cs, rx);
            @(negedge CLK50);
            if (SPI_START === 1'b1) overlap++;
            @(negedge CLK50);
            if (SPI_START === 1'b1) overlap++;
            SPI_RX   = rx;
            SPI_DONE = 1'b1;
         end
      end
   end

   int log_base = 0;

   task automatic run_seq(input bit inject, output int nbytes);
      bit injected;
      int cyc;
      injected = 1'b0;
      cyc      = 0;
      run_id++;
      log_base = tx_log.size();
      @(negedge CLK50);
      START = 1'b1;
      @(negedge CLK50);
      START = 1'b0;
      check("status_cleared", {READY, ERR, ERR_CODE, SDHC}, 6'b0);
      while (!(READY || ERR) && cyc < 5000) begin
         @(negedge CLK50);
         START = 1'b0;
         cyc++;
         if (inject && !injected && SPI_TX == 8'h48 && CS == 1'b0) begin
            START    = 1'b1;
            injected = 1'b1;
         end
      end
      START = 1'b0;
      check("run_bounded", 48'(cyc < 5000), 48'd1);
      nbytes = tx_log.size() - log_base;
   endtask

   task automatic check_prefix();
      int idx, ff_hi;
      logic [47:0] frm;
      idx   = 0;
      ff_hi = 0;
      while (log_base + idx < tx_log.size() &&
             !(tx_log[log_base + idx] == 8'h40 && cs_log[log_base + idx] == 1'b0)) begin
         if (tx_log[log_base + idx] == 8'hFF && cs_log[log_base + idx] == 1'b1) ff_hi++;
         idx++;
      end
      check("cmd0_index", 48'(idx), 48'd10);
      check("powerup_ff_cs_high", 48'(ff_hi), 48'd10);
      frm = '0;
      for (int i = 0; i < 6; i++)
         if (log_base + idx + i < tx_log.size()) frm = {frm[39:0], tx_log[log_base + idx + i]};
      check("cmd0_frame", frm, 48'h400000000095);
   endtask

   initial begin : stim
      int n1, n2, n;
      int cyc;

      #3 RST_N = 1'b0;
      #12;
      check("rst_outputs", {CS, SPI_START, SPI_TX, READY, SDHC, ERR, ERR_CODE},
            {1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0});
      @(negedge CLK50);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK50);

      // nominal SDHC card
      run_seq(1'b0, n1);
      check("sdhc_status", {READY, SDHC, ERR, ERR_CODE, CS}, {1'b1, 1'b1, 1'b0, 3'd0, 1'b1});
      check_prefix();
      check("cmd55_count", 48'(n_cmd55), 48'd4);
      check("acmd41_count", 48'(n_acmd41), 48'd4);

      // restart from DONE with a START pulse during CMD8
      run_seq(1'b1, n2);
      check("rerun_status", {READY, SDHC, ERR}, 3'b110);
      check("rerun_bytes", 48'(n2), 48'(n1));

      // SDSC card
      cfg_ocr = 32'h80FF8000;
      run_seq(1'b0, n);
      check("sdsc_status", {READY, SDHC, ERR}, 3'b100);

      // card never answers
      cfg_no_resp = 1'b1;
      run_seq(1'b0, n);
      check("ncr_status", {READY, ERR, ERR_CODE, CS}, {1'b0, 1'b1, 3'd5, 1'b1});
      check("ncr_bytes", 48'(n), 48'd24);
      cfg_no_resp = 1'b0;

      // bad CMD8 echo
      cfg_cmd8_tail = 32'h000001AB;
      run_seq(1'b0, n);
      check("cmd8_echo", {READY, ERR, ERR_CODE}, {1'b0, 1'b1, 3'd2});
      cfg_cmd8_tail = 32'h000001AA;

      // ACMD41 never leaves idle
      cfg_busy = 1000;
      run_seq(1'b0, n);
      check("acmd41_timeout", {READY, ERR, ERR_CODE}, {1'b0, 1'b1, 3'd3});
      check("acmd41_frames", 48'(n_acmd41), 48'd4);
      cfg_busy = 3;
      cfg_ocr  = 32'hC0FF8000;

      // reset in the middle of an ACMD41 frame
      run_id++;
      @(negedge CLK50);
      START = 1'b1;
      @(negedge CLK50);
      START = 1'b0;
      cyc = 0;
      while (!(SPI_TX == 8'h69 && CS == 1'b0) && cyc < 5000) begin
         @(negedge CLK50);
         cyc++;
      end
      check("reach_acmd41", 48'(cyc < 5000), 48'd1);
      repeat (2) @(negedge CLK50);
      #2 RST_N = 1'b0;
      #1;
      check("midrst_outputs", {CS, SPI_START, SPI_TX, READY, SDHC, ERR, ERR_CODE},
            {1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0});
      repeat (3) @(negedge CLK50);
      RST_N = 1'b1;
      repeat (10) @(negedge CLK50);
      check("midrst_idle", {CS, SPI_START, READY, ERR}, 4'b1000);
      run_seq(1'b0, n);
      check("after_rst_status", {READY, SDHC, ERR}, 3'b110);
      check("after_rst_bytes", 48'(n), 48'(n1));
      check_prefix();

      check("no_overlap", 48'(overlap), 48'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
